// File: rtl/sseg_ctrl.sv
// sseg_ctrl: serialises a 16-bit hex value into a clear + four-digit byte frame for the SPI byte sender.
// Define SSEG_BRIGHT_EN to prefix every frame with the brightness command 0x7A and the bri snapshot.
module sseg_ctrl #(
    parameter logic [31:0] REFRESH_CYC = 32'd0,
    parameter bit          BLANK_LZ    = 1'b0,
    parameter logic [7:0]  BLANK_CODE  = 8'h78,
    parameter logic [7:0]  CLR_CODE    = 8'h76
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] val,
    input  logic        upd,
    input  logic [7:0]  bri,
    output logic        spi_req,
    output logic [7:0]  spi_dat,
    input  logic        spi_snt,
    output logic        busy,
    output logic        done
);
`ifdef SSEG_BRIGHT_EN
    localparam int NB = 7;
    localparam logic [7:0] FIRST = 8'h7A;
    logic [7:0] bri_q;
`else
    localparam int NB = 5;
    localparam logic [7:0] FIRST = CLR_CODE;
    logic unused_bri;
    assign unused_bri = ^bri;
`endif
    typedef enum logic [1:0] {IDLE, SEND, WAIT} state_t;
    state_t      state;
    logic [15:0] val_q;
    logic [2:0]  idx;
    logic        pending;
    logic [31:0] cnt;
    logic [3:0]  blank;
    logic [7:0]  frame [8];
    logic        refresh_hit;
    logic        trig;
    logic        last;
    assign refresh_hit = (REFRESH_CYC != 32'd0) && (cnt == REFRESH_CYC - 32'd1);
    assign trig        = upd || pending || refresh_hit;
    assign last        = idx == 3'(NB - 1);
    // blanking ripples down from d3 until the first nonzero digit and never reaches d0
    always_comb begin
        blank[3] = BLANK_LZ && (val_q[15:12] == 4'h0);
        blank[2] = blank[3] && (val_q[11:8] == 4'h0);
        blank[1] = blank[2] && (val_q[7:4] == 4'h0);
        blank[0] = 1'b0;
    end
    always_comb begin
        for (int i = 0; i < 8; i++) frame[i] = 8'h00;
`ifdef SSEG_BRIGHT_EN
        frame[0] = 8'h7A;
        frame[1] = bri_q;
        frame[2] = CLR_CODE;
`else
        frame[0] = CLR_CODE;
`endif
        for (int i = 0; i < 4; i++)
            frame[NB-4+i] = blank[3-i] ? BLANK_CODE : {4'h0, val_q[(3-i)*4 +: 4]};
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            spi_req <= 1'b0;
            spi_dat <= 8'h00;
            busy    <= 1'b0;
            done    <= 1'b0;
            pending <= 1'b0;
            cnt     <= 32'd0;
            idx     <= 3'd0;
            val_q   <= 16'h0000;
`ifdef SSEG_BRIGHT_EN
            bri_q   <= 8'h00;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (trig) begin
                        val_q   <= val;
`ifdef SSEG_BRIGHT_EN
                        bri_q   <= bri;
`endif
                        idx     <= 3'd0;
                        spi_dat <= FIRST;
                        spi_req <= 1'b1;
                        busy    <= 1'b1;
                        pending <= 1'b0;
                        cnt     <= 32'd0;
                        state   <= SEND;
                    end else begin
                        cnt <= cnt + 32'd1;
                    end
                end
                SEND: begin
                    pending <= pending | upd;
                    if (spi_snt) begin
                        spi_req <= 1'b0;
                        state   <= WAIT;
                    end
                end
                WAIT: begin
                    pending <= pending | upd;
                    if (!spi_snt) begin
                        if (last) begin
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            state <= IDLE;
                        end else begin
                            idx     <= idx + 3'd1;
                            spi_dat <= frame[idx + 3'd1];
                            spi_req <= 1'b1;
                            state   <= SEND;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sseg_ctrl.sv
// tb_sseg_ctrl: three sseg_ctrl instances (plain, leading-zero blanking, 100-cycle refresh)
// each driven by an SPI responder model and checked against a per-instance byte scoreboard.
module tb_sseg_ctrl;
`ifdef SSEG_BRIGHT_EN
    localparam logic [7:0] FIRST_B = 8'h7A;
`else
    localparam logic [7:0] FIRST_B = 8'h76;
`endif
    logic             clk = 1'b0;
    logic [2:0]       rst_n;
    logic [2:0]       upd;
    logic [2:0][15:0] val;
    logic [7:0]       bri;
    logic [2:0]       req;
    logic [2:0][7:0]  dat;
    logic [2:0]       busy;
    logic [2:0]       done;
    logic [2:0][31:0] nb_w;
    logic [2:0][31:0] nd_w;
    logic [7:0]       exp_q [3][$];
    int               n_run = 0;
    int               n_fail = 0;

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    for (genvar g = 0; g < 3; g++) begin : u
        logic       snt_l;
        logic       req_p;
        logic [1:0] sc;
        int         nb = 0;
        int         nd = 0;
        sseg_ctrl #(.REFRESH_CYC(g == 2 ? 32'd100 : 32'd0), .BLANK_LZ(g == 1)) dut (
            .clk(clk), .rst_n(rst_n[g]), .val(val[g]), .upd(upd[g]), .bri(bri),
            .spi_req(req[g]), .spi_dat(dat[g]), .spi_snt(snt_l),
            .busy(busy[g]), .done(done[g]));
        // snt rises two cycles after req, falls one cycle after req drops
        always @(posedge clk or negedge rst_n[g]) begin
            if (!rst_n[g]) begin
                snt_l <= 1'b0;
                sc    <= 2'd0;
            end else if (req[g] && !snt_l) begin
                sc <= sc + 2'd1;
                if (sc == 2'd1) snt_l <= 1'b1;
            end else begin
                sc <= 2'd0;
                if (!req[g]) snt_l <= 1'b0;
            end
        end
        always @(negedge clk) begin
            if (!rst_n[g]) begin
                req_p <= 1'b0;
            end else begin
                req_p <= req[g];
                if (done[g]) nd <= nd + 1;
                if (req[g] && !req_p) begin
                    nb <= nb + 1;
                    if (exp_q[g].size() == 0) chk("queue_empty", exp_q[g].size(), 1);
                    else chk("byte", {24'h0, dat[g]}, {24'h0, exp_q[g].pop_front()});
                end
            end
        end
        assign nb_w[g] = 32'(nb);
        assign nd_w[g] = 32'(nd);
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push_frame(input int g, input logic [15:0] v);
        bit lead;
        logic [3:0] d;
        lead = (g == 1);
`ifdef SSEG_BRIGHT_EN
        exp_q[g].push_back(8'h7A);
        exp_q[g].push_back(bri);
`endif
        exp_q[g].push_back(8'h76);
        for (int i = 3; i >= 0; i--) begin
            d = v[i*4 +: 4];
            if (lead && d == 4'h0 && i != 0) exp_q[g].push_back(8'h78);
            else begin
                lead = 1'b0;
                exp_q[g].push_back({4'h0, d});
            end
        end
    endtask

    task automatic pulse(input int g, input logic [15:0] v);
        val[g] = v;
        upd[g] = 1'b1;
        tick(1);
        upd[g] = 1'b0;
    endtask

    task automatic wait_busy(input int g, input logic lvl, input string tag);
        int n;
        n = 0;
        while (busy[g] !== lvl && n < 400) begin
            tick(1);
            n++;
        end
        chk(tag, {31'h0, busy[g]}, {31'h0, lvl});
    endtask

    initial begin
        int n;
        logic [31:0] nd0, nb0;
        rst_n = '0;
        upd   = '0;
        bri   = 8'h40;
        val[0] = 16'h0;
        val[1] = 16'h0;
        val[2] = 16'h00BE;
        tick(3);
        for (int g = 0; g < 3; g++) begin
            chk("rst_req", {31'h0, req[g]}, 0);
            chk("rst_dat", {24'h0, dat[g]}, 0);
            chk("rst_busy", {31'h0, busy[g]}, 0);
            chk("rst_done", {31'h0, done[g]}, 0);
        end
        rst_n = '1;
        // auto refresh: three frames, gap of 100 idle cycles, upd coincident with expiry
        for (int i = 0; i < 3; i++) push_frame(2, 16'h00BE);
        wait_busy(2, 1'b1, "refresh_first");
        wait_busy(2, 1'b0, "refresh_first_end");
        n = 0;
        while (!busy[2] && n < 400) begin
            tick(1);
            n++;
        end
        chk("refresh_gap", n, 100);
        wait_busy(2, 1'b0, "refresh_second_end");
        tick(99);
        pulse(2, 16'h00BE);
        chk("coincident_start", {31'h0, busy[2]}, 1);
        wait_busy(2, 1'b0, "coincident_end");
        tick(50);
        chk("coincident_single", {31'h0, busy[2]}, 0);
        chk("refresh_queue", exp_q[2].size(), 0);
        rst_n[2] = 1'b0;
        // basic frame and one-cycle latency
        nd0 = nd_w[0];
        push_frame(0, 16'h12AF);
        pulse(0, 16'h12AF);
        chk("req_latency", {31'h0, req[0]}, 1);
        chk("busy_on", {31'h0, busy[0]}, 1);
        chk("first_byte", {24'h0, dat[0]}, {24'h0, FIRST_B});
        wait_busy(0, 1'b0, "frame_end");
        tick(2);
        chk("done_count", nd_w[0] - nd0, 1);
        chk("busy_after", {31'h0, busy[0]}, 0);
        chk("frame_queue", exp_q[0].size(), 0);
        // leading-zero blanking
        push_frame(1, 16'h0040);
        pulse(1, 16'h0040);
        wait_busy(1, 1'b0, "blank_end1");
        tick(2);
        push_frame(1, 16'h0000);
        pulse(1, 16'h0000);
        wait_busy(1, 1'b0, "blank_end2");
        tick(2);
        chk("blank_queue", exp_q[1].size(), 0);
        // updates during a frame collapse into one follow-up frame with the latest val
        nd0 = nd_w[0];
        push_frame(0, 16'h5555);
        push_frame(0, 16'h3333);
        pulse(0, 16'h5555);
        tick(3);
        pulse(0, 16'h1111);
        tick(3);
        pulse(0, 16'h2222);
        tick(3);
        pulse(0, 16'h3333);
        wait_busy(0, 1'b0, "pend_first_end");
        tick(1);
        chk("pend_start", {31'h0, busy[0]}, 1);
        wait_busy(0, 1'b0, "pend_second_end");
        tick(20);
        chk("pend_no_extra", {31'h0, busy[0]}, 0);
        chk("pend_done_count", nd_w[0] - nd0, 2);
        chk("pend_queue", exp_q[0].size(), 0);
        // reset while waiting after the third byte abandons the frame
        push_frame(0, 16'hBEEF);
        nb0 = nb_w[0];
        pulse(0, 16'hBEEF);
        n = 0;
        while (!(nb_w[0] == nb0 + 3 && !req[0]) && n < 400) begin
            tick(1);
            n++;
        end
        chk("reach_wait3", nb_w[0] - nb0, 3);
        rst_n[0] = 1'b0;
        #1;
        chk("rst_mid_req", {31'h0, req[0]}, 0);
        chk("rst_mid_busy", {31'h0, busy[0]}, 0);
        exp_q[0].delete();
        tick(2);
        rst_n[0] = 1'b1;
        nb0 = nb_w[0];
        tick(60);
        chk("rst_no_resume", nb_w[0] - nb0, 0);
        chk("rst_idle_busy", {31'h0, busy[0]}, 0);
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, %0d failed so far", n_fail);
        $fatal(1, "time limit");
    end
endmodule
